// File: rtl/nn_pkg.sv
// Shared types and default sizes for the NN traversal sequencer.
package nn_pkg;
    localparam int NODE_WIDTH_DEF  = 8;
    localparam int SHAPE_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/nn_sequencer_if.sv
// Config, run handshake and step-index bundle between the NN sequencer and its host/datapath.
interface nn_sequencer_if
    import nn_pkg::*;
#(
    parameter int NODE_WIDTH  = NODE_WIDTH_DEF,
    parameter int SHAPE_DEPTH = SHAPE_DEPTH_DEF
);
    localparam int LAYER_WIDTH  = $clog2(SHAPE_DEPTH);
    localparam int WEIGHT_WIDTH = NODE_WIDTH + 1;

    logic                    cfg_we;
    logic [LAYER_WIDTH-1:0]  cfg_addr;
    logic [NODE_WIDTH-1:0]   cfg_data;
    logic                    start;
    logic                    step_en;
    logic                    busy;
    logic                    valid;
    logic [WEIGHT_WIDTH-1:0] weight_idx;
    logic [NODE_WIDTH-1:0]   node_idx;
    logic [LAYER_WIDTH-1:0]  layer_idx;
    logic                    node_last;
    logic                    layer_last;
    logic                    model_last;
    logic                    mem_select;
    logic                    done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, step_en,
        input  busy, valid, weight_idx, node_idx, layer_idx,
               node_last, layer_last, model_last, mem_select, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, step_en,
        output busy, valid, weight_idx, node_idx, layer_idx,
               node_last, layer_last, model_last, mem_select, done
    );
endinterface

// File: rtl/nn_step_counter.sv
// Wrapping index counter: counts 0..limit_i on en_i, sync clear wins over enable.
module nn_step_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == limit_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = last_o ? '0 : cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/nn_sequencer.sv
// NN traversal sequencer: walks weight -> node -> layer over a run-time loaded shape table.
// Optional bias slot per node when NN_SEQ_BIAS_EN is defined.
module nn_sequencer
    import nn_pkg::*;
#(
    parameter int NODE_WIDTH  = NODE_WIDTH_DEF,
    parameter int SHAPE_DEPTH = SHAPE_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    nn_sequencer_if.slave  bus
);
    localparam int LAYER_WIDTH  = $clog2(SHAPE_DEPTH);
    localparam int WEIGHT_WIDTH = NODE_WIDTH + 1;
    localparam logic [LAYER_WIDTH-1:0] LAST_PAIR = LAYER_WIDTH'(SHAPE_DEPTH - 2);

    seq_state_t              state_q;
    logic                    busy_q, done_q;
    logic [NODE_WIDTH-1:0]   shape_q [SHAPE_DEPTH];

    logic [WEIGHT_WIDTH-1:0] weight_cnt, weight_lim;
    logic [NODE_WIDTH-1:0]   node_cnt, node_lim;
    logic [LAYER_WIDTH-1:0]  layer_cnt, layer_nxt, layer_nxt2;
    logic [NODE_WIDTH-1:0]   shape_cur, shape_nxt, shape_nxt2, shape0_eff, shape1_eff;
    logic                    weight_wrap, node_wrap, at_table_end;
    logic                    cfg_ok, accept, cnt_clr;
    logic                    node_last, layer_last, model_last;

    // A write in the same IDLE cycle as start must already count for the start check.
    assign cfg_ok     = bus.cfg_we && !busy_q;
    assign shape0_eff = (cfg_ok && bus.cfg_addr == '0) ? bus.cfg_data : shape_q[0];
    assign shape1_eff = (cfg_ok && bus.cfg_addr == LAYER_WIDTH'(1)) ? bus.cfg_data : shape_q[1];

    assign layer_nxt  = layer_cnt + LAYER_WIDTH'(1);
    assign layer_nxt2 = layer_cnt + LAYER_WIDTH'(2);
    assign shape_cur  = shape_q[layer_cnt];
    assign shape_nxt  = shape_q[layer_nxt];
    // At the last table pair l+2 would run off the table, so treat it as the end marker.
    assign shape_nxt2 = at_table_end ? '0 : shape_q[layer_nxt2];

`ifdef NN_SEQ_BIAS_EN
    assign weight_lim = {1'b0, shape_cur};
`else
    assign weight_lim = {1'b0, shape_cur} - WEIGHT_WIDTH'(1);
`endif
    assign node_lim   = shape_nxt - NODE_WIDTH'(1);

    assign node_last  = busy_q && weight_wrap;
    assign layer_last = node_last && node_wrap;
    assign model_last = layer_last && (at_table_end || shape_nxt2 == '0);
    assign accept     = busy_q && bus.step_en;
    assign cnt_clr    = !busy_q || (accept && model_last);

    nn_step_counter #(.WIDTH(WEIGHT_WIDTH)) u_weight (
        .clk(clk), .reset_n(reset_n), .en_i(accept), .clr_i(cnt_clr),
        .limit_i(weight_lim), .cnt_o(weight_cnt), .last_o(weight_wrap)
    );

    nn_step_counter #(.WIDTH(NODE_WIDTH)) u_node (
        .clk(clk), .reset_n(reset_n), .en_i(accept && node_last), .clr_i(cnt_clr),
        .limit_i(node_lim), .cnt_o(node_cnt), .last_o(node_wrap)
    );

    // Layer end is decided by model_last; its limit flag only marks the last table pair.
    nn_step_counter #(.WIDTH(LAYER_WIDTH)) u_layer (
        .clk(clk), .reset_n(reset_n), .en_i(accept && layer_last), .clr_i(cnt_clr),
        .limit_i(LAST_PAIR), .cnt_o(layer_cnt), .last_o(at_table_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SHAPE_DEPTH; i++)
                shape_q[i] <= '0;
        end else if (cfg_ok) begin
            shape_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (shape0_eff != '0 && shape1_eff != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept && model_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.valid      = busy_q;
    assign bus.done       = done_q;
    assign bus.weight_idx = weight_cnt;
    assign bus.node_idx   = node_cnt;
    assign bus.layer_idx  = layer_cnt;
    assign bus.node_last  = node_last;
    assign bus.layer_last = layer_last;
    assign bus.model_last = model_last;
    assign bus.mem_select = layer_cnt[0];
endmodule

// File: tb/tb_nn_sequencer.sv
// Bench for nn_sequencer: step-list model checked every cycle plus literal per-run expectations.
// Honours NN_SEQ_BIAS_EN the same way as the design.
module tb_nn_sequencer;
    localparam int NW    = 8;
    localparam int DEPTH = 8;
`ifdef NN_SEQ_BIAS_EN
    localparam int BIAS = 1;
    localparam int T1_STEPS = 8,  T1_DONE = 9;
    localparam logic [31:0] T1_NL = 32'h88, T1_ML = 32'h80;
    localparam int T2_STEPS = 12;
    localparam logic [31:0] T2_MS = 32'hFC0;
    localparam int T7_STEPS = 10;
`else
    localparam int BIAS = 0;
    localparam int T1_STEPS = 6,  T1_DONE = 7;
    localparam logic [31:0] T1_NL = 32'h24, T1_ML = 32'h20;
    localparam int T2_STEPS = 8;
    localparam logic [31:0] T2_MS = 32'hF0;
    localparam int T7_STEPS = 8;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nn_sequencer_if #(.NODE_WIDTH(NW), .SHAPE_DEPTH(DEPTH)) bus ();
    nn_sequencer #(.NODE_WIDTH(NW), .SHAPE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct { int w; int n; int l; bit nl; bit ll; } step_t;

    int    tbl [DEPTH];
    step_t exp_q [$];
    bit    mbusy, mdone;
    int    acc, cyc, done_cyc;
    bit    done_seen, valid_seen;
    logic [31:0] nl_mask, ml_mask, ms_mask;

    // Expected step list of a whole run, straight from the shape table.
    task automatic build_run();
        exp_q.delete();
        for (int l = 0; l + 1 < DEPTH && tbl[l] != 0 && tbl[l+1] != 0; l++)
            for (int n = 0; n < tbl[l+1]; n++)
                for (int w = 0; w < tbl[l] + BIAS; w++) begin
                    step_t s;
                    s.w  = w;
                    s.n  = n;
                    s.l  = l;
                    s.nl = (w == tbl[l] + BIAS - 1);
                    s.ll = s.nl && (n == tbl[l+1] - 1);
                    exp_q.push_back(s);
                end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ctrl", {bus.busy, bus.valid, bus.done}, 0);
            chk("rst_idx", {bus.weight_idx, bus.node_idx, bus.layer_idx}, 0);
            foreach (tbl[i]) tbl[i] = 0;
            exp_q.delete();
            mbusy = 0;
            mdone = 0;
        end else begin
            chk("busy", bus.busy, mbusy);
            chk("valid", bus.valid, mbusy);
            chk("done", bus.done, mdone);
            if (mbusy && exp_q.size() > 0) begin
                chk("weight_idx", bus.weight_idx, exp_q[0].w);
                chk("node_idx", bus.node_idx, exp_q[0].n);
                chk("layer_idx", bus.layer_idx, exp_q[0].l);
                chk("node_last", bus.node_last, exp_q[0].nl);
                chk("layer_last", bus.layer_last, exp_q[0].ll);
                chk("model_last", bus.model_last, exp_q.size() == 1);
                chk("mem_select", bus.mem_select, exp_q[0].l % 2);
            end else begin
                chk("idle_flags", {bus.node_last, bus.layer_last, bus.model_last}, 0);
            end

            cyc++;
            if (bus.valid) valid_seen = 1;
            if (bus.done) begin
                done_seen = 1;
                done_cyc  = cyc;
            end

            if (mdone) begin
                mdone = 0;
            end else if (mbusy) begin
                if (bus.step_en) begin
                    if (acc < 32) begin
                        nl_mask[acc] = bus.node_last;
                        ml_mask[acc] = bus.model_last;
                        ms_mask[acc] = bus.mem_select;
                    end
                    acc++;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        mbusy = 0;
                        mdone = 1;
                    end
                end
            end else begin
                if (bus.cfg_we) tbl[bus.cfg_addr] = bus.cfg_data;
                if (bus.start) begin
                    build_run();
                    acc = 0; cyc = 0; done_cyc = 0;
                    done_seen = 0; valid_seen = 0;
                    nl_mask = 0; ml_mask = 0; ms_mask = 0;
                    if (exp_q.size() == 0) mdone = 1;
                    else mbusy = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(addr);
        bus.cfg_data = 8'(data);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_wait(input int budget, input bit toggle);
        int i = 0;
        while (!done_seen && i < budget) begin
            if (toggle) bus.step_en = ~bus.step_en;
            tick();
            i++;
        end
        chk("run_completes", done_seen, 1);
        bus.step_en = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b1;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
        bus.start = 0; bus.step_en = 1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.busy, bus.valid, bus.done, bus.node_last,
                              bus.layer_last, bus.model_last, bus.mem_select}, 0);
        reset_n = 1'b1;
        tick();

        // {3,2,0} free-running
        cfg_write(0, 3);
        cfg_write(1, 2);
        pulse_start();
        run_wait(100, 0);
        chk("t1_steps", acc, T1_STEPS);
        chk("t1_node_last_at", nl_mask, T1_NL);
        chk("t1_model_last_at", ml_mask, T1_ML);
        chk("t1_done_cycle", done_cyc, T1_DONE);

        // {2,2,2,0} two layers, ping-pong select
        cfg_write(0, 2);
        cfg_write(2, 2);
        pulse_start();
        run_wait(100, 0);
        chk("t2_steps", acc, T2_STEPS);
        chk("t2_mem_select", ms_mask, T2_MS);

        // {3,2,0} with stalls every other cycle
        cfg_write(0, 3);
        cfg_write(2, 0);
        pulse_start();
        run_wait(100, 1);
        chk("t3_stall_steps", acc, T1_STEPS);

        // write while busy is dropped
        pulse_start();
        tick();
        cfg_write(1, 5);
        run_wait(100, 0);
        chk("t4_first_steps", acc, T1_STEPS);
        pulse_start();
        run_wait(100, 0);
        chk("t4_second_steps", acc, T1_STEPS);

        // {4,0}: straight to done
        cfg_write(0, 4);
        cfg_write(1, 0);
        pulse_start();
        run_wait(20, 0);
        chk("t5_no_valid", valid_seen, 0);
        chk("t5_done_cycle", done_cyc, 1);

        // write and start together: {4,2,0}
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_data = 8'd2;
        bus.start = 1'b1;
        tick();
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        run_wait(100, 0);
        chk("t6_steps", acc, T7_STEPS);

        // reset mid-run on step 3 of {3,2,0}
        cfg_write(0, 3);
        pulse_start();
        tick();
        tick();
        chk("t7_on_step3", bus.weight_idx, 2);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_ctrl", {bus.busy, bus.valid, bus.done}, 0);
        chk("t7_rst_idx", {bus.weight_idx, bus.node_idx, bus.layer_idx}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        run_wait(20, 0);
        chk("t7_cleared_no_valid", valid_seen, 0);
        chk("t7_cleared_done_cycle", done_cyc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
